// File: rtl/imem_boot_loader.sv
// Instruction memory with a byte-stream boot loader; holds the cpu in reset
// until the image is loaded, then serves combinational instruction fetches.
module imem_boot_loader #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0040_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_byte,
   input  logic                  in_last,
   input  logic [31:0]           instr_addr,
   output logic [31:0]           instr,
   output logic                  cpu_rst,
   output logic                  load_done,
   output logic [DEPTH_LOG2:0]   word_count,
   output logic                  err_overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {LOAD, RUN, ERR} state_t;

   state_t                state;
   logic [1:0]            byte_idx;
   logic [DEPTH_LOG2:0]   word_ptr;
   logic [31:0]           asm_word;
   logic [31:0]           asm_next;
   logic [31:0]           mem [DEPTH];

   logic                  accept;
   logic                  mem_full;
   logic                  word_end;
   logic                  mem_we;

   assign in_ready     = (state == LOAD);
   assign cpu_rst      = (state != RUN);
   assign load_done    = (state == RUN);
   assign err_overflow = (state == ERR);
   assign word_count   = word_ptr;

   assign accept   = in_valid & in_ready;
   // word_ptr can only reach DEPTH, so its top bit alone flags a full memory
   assign mem_full = word_ptr[DEPTH_LOG2];
   assign word_end = (byte_idx == 2'd3) | in_last;
   assign mem_we   = accept & ~mem_full & word_end;

   // Big-endian placement: byte 0 of a word is the MSB
   always_comb begin
      asm_next = asm_word;
      case (byte_idx)
         2'd0:    asm_next[31:24] = in_byte;
         2'd1:    asm_next[23:16] = in_byte;
         2'd2:    asm_next[15:8]  = in_byte;
         default: asm_next[7:0]   = in_byte;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= LOAD;
         byte_idx <= 2'd0;
         word_ptr <= '0;
         asm_word <= '0;
      end else if (accept) begin
         if (mem_full) begin
            state <= ERR;
         end else if (word_end) begin
            word_ptr <= word_ptr + 1'b1;
            byte_idx <= 2'd0;
            asm_word <= '0;
            if (in_last)
               state <= RUN;
         end else begin
            asm_word <= asm_next;
            byte_idx <= byte_idx + 2'd1;
         end
      end
   end

   // Memory is never cleared; a fresh load simply overwrites from word 0
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[word_ptr[DEPTH_LOG2-1:0]] <= asm_next;
   end

   logic [31:0] rd_offset;
   logic [31:0] rd_index;
   logic        rd_hit;

   assign rd_offset = instr_addr - BASE_ADDR;
   assign rd_index  = rd_offset >> 2;
   assign rd_hit    = (state == RUN) &&
                      (instr_addr[1:0] == 2'b00) &&
                      (instr_addr >= BASE_ADDR) &&
                      (rd_index < {{(31-DEPTH_LOG2){1'b0}}, word_ptr});

   assign instr = rd_hit ? mem[rd_index[DEPTH_LOG2-1:0]] : 32'h0000_0000;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed scenarios plus randomized images,
// checked against a queue-based reference model of the loaded image.
module tb_imem_boot_loader;

   localparam logic [31:0] BASE = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_byte = 8'h00;
   logic        in_last = 1'b0;
   logic [31:0] instr_addr = BASE;
   logic        sel = 1'b0;

   logic        ready_a, cpu_rst_a, done_a, err_a;
   logic [31:0] instr_a;
   logic [10:0] wc_a;
   logic        ready_b, cpu_rst_b, done_b, err_b;
   logic [31:0] instr_b;
   logic [2:0]  wc_b;

   always #5 clk = ~clk;

   imem_boot_loader dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(ready_a),
      .in_byte(in_byte), .in_last(in_last), .instr_addr(instr_addr),
      .instr(instr_a), .cpu_rst(cpu_rst_a), .load_done(done_a),
      .word_count(wc_a), .err_overflow(err_a)
   );

   imem_boot_loader #(.DEPTH_LOG2(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(ready_b),
      .in_byte(in_byte), .in_last(in_last), .instr_addr(instr_addr),
      .instr(instr_b), .cpu_rst(cpu_rst_b), .load_done(done_b),
      .word_count(wc_b), .err_overflow(err_b)
   );

   logic        obs_ready, obs_cpu_rst, obs_done, obs_err;
   logic [31:0] obs_instr, obs_wc;
   assign obs_ready   = sel ? ready_b   : ready_a;
   assign obs_cpu_rst = sel ? cpu_rst_b : cpu_rst_a;
   assign obs_done    = sel ? done_b    : done_a;
   assign obs_err     = sel ? err_b     : err_a;
   assign obs_instr   = sel ? instr_b   : instr_a;
   assign obs_wc      = sel ? 32'(wc_b) : 32'(wc_a);

   int errors = 0;
   int checks = 0;

   // Reference model: image as an array of words plus a pending-byte queue
   logic [31:0] m_mem [0:1023];
   logic [7:0]  m_bytes [$];
   int          m_cnt;
   int          m_depth;
   bit          m_run, m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_cnt = 0;
      m_bytes.delete();
      m_run = 0;
      m_err = 0;
      m_depth = sel ? 4 : 1024;
   endfunction

   function automatic void model_accept(input logic [7:0] b, input bit last);
      logic [31:0] w;
      if (m_run || m_err) return;
      if (m_cnt == m_depth) begin
         m_err = 1;
         return;
      end
      m_bytes.push_back(b);
      if (m_bytes.size() == 4 || last) begin
         w = 0;
         foreach (m_bytes[i]) w = w | (32'(m_bytes[i]) << (24 - 8 * i));
         m_mem[m_cnt] = w;
         m_cnt++;
         m_bytes.delete();
         if (last) m_run = 1;
      end
   endfunction

   function automatic logic [31:0] model_instr(input logic [31:0] addr);
      longint idx;
      if (!m_run || addr[1:0] != 2'b00 || addr < BASE) return 32'h0;
      idx = longint'(addr - BASE) / 4;
      if (idx >= m_cnt) return 32'h0;
      return m_mem[idx];
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic send(input logic [7:0] b, input bit last, input int gap);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_byte = b;
      in_last = last;
      n = 0;
      while (!obs_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!obs_ready) begin
         check("ready_timeout", {31'b0, obs_ready}, 32'h1);
      end else begin
         model_accept(b, last);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      repeat (gap) begin
         @(negedge clk);
         in_last = 1'($urandom);
         in_byte = 8'($urandom);
         check("gap_ready", {31'b0, obs_ready}, {31'b0, !(m_run || m_err)});
      end
      in_last = 1'b0;
   endtask

   task automatic read_chk(input logic [31:0] addr);
      @(negedge clk);
      instr_addr = addr;
      #1;
      check($sformatf("instr@%h", addr), obs_instr, model_instr(addr));
   endtask

   task automatic check_status(input string tag);
      @(negedge clk);
      check({tag, "_ready"},   {31'b0, obs_ready},   {31'b0, !(m_run || m_err)});
      check({tag, "_cpu_rst"}, {31'b0, obs_cpu_rst}, {31'b0, !m_run});
      check({tag, "_done"},    {31'b0, obs_done},    {31'b0, m_run});
      check({tag, "_err"},     {31'b0, obs_err},     {31'b0, m_err});
      check({tag, "_wc"},      obs_wc,               32'(m_cnt));
   endtask

   task automatic send_list(input logic [7:0] b [$], input int gap);
      for (int i = 0; i < b.size(); i++) begin
         if (m_run || m_err) break;
         send(b[i], i == b.size() - 1, gap);
      end
   endtask

   initial begin
      logic [7:0] img [$];
      int len;

      // Reset state on both instances
      sel = 1'b0;
      apply_reset();
      check_status("reset_a");
      read_chk(BASE);
      sel = 1'b1;
      model_reset();
      check_status("reset_b");
      sel = 1'b0;
      model_reset();

      // Two-word image, back to back
      img = '{8'h3C, 8'h08, 8'h00, 8'h01, 8'h21, 8'h09, 8'h00, 8'h02};
      send_list(img, 0);
      check_status("img8");
      read_chk(32'h0040_0000);
      read_chk(32'h0040_0004);
      check("img8_word1", obs_instr, 32'h2109_0002);
      read_chk(32'h0040_0008);
      read_chk(32'h0040_0002);
      read_chk(32'h003F_FFFC);

      // Partial final word is zero-padded
      apply_reset();
      img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
      send_list(img, 0);
      check_status("img6");
      read_chk(32'h0040_0004);
      check("img6_word1", obs_instr, 32'h1122_0000);
      read_chk(32'h0040_0000);

      // Gaps of five cycles between every byte
      apply_reset();
      img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_list(img, 5);
      check_status("gaps");
      read_chk(BASE);
      check("gaps_word0", obs_instr, 32'hDEAD_BEEF);

      // Small memory: 17 bytes overflow, 16 bytes fit exactly
      sel = 1'b1;
      apply_reset();
      img.delete();
      for (int i = 0; i < 17; i++) img.push_back(8'(i + 1));
      send_list(img, 0);
      check_status("ovf17");
      check("ovf17_err", {31'b0, obs_err}, 32'h1);
      read_chk(BASE);
      apply_reset();
      img.delete();
      for (int i = 0; i < 16; i++) img.push_back(8'(8'h80 + i));
      send_list(img, 0);
      check_status("fit16");
      check("fit16_done", {31'b0, obs_done}, 32'h1);
      read_chk(32'h0040_000C);
      read_chk(32'h0040_0010);
      sel = 1'b0;

      // Reset in the middle of a load
      apply_reset();
      img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      for (int i = 0; i < 5; i++) send(img[i], 1'b0, 0);
      apply_reset();
      check_status("midrst");
      img = '{8'h12, 8'h34, 8'h56, 8'h78};
      send_list(img, 0);
      check_status("reload");
      read_chk(BASE);
      check("reload_word0", obs_instr, 32'h1234_5678);
      read_chk(32'h0040_0004);

      // Randomized images on both memory sizes
      for (int it = 0; it < 16; it++) begin
         sel = it[0];
         apply_reset();
         len = sel ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 24));
         img.delete();
         for (int i = 0; i < len; i++) img.push_back(8'($urandom));
         for (int i = 0; i < len; i++) begin
            if (m_run || m_err) break;
            send(img[i], i == len - 1, int'($urandom_range(0, 2)));
         end
         check_status($sformatf("rand%0d", it));
         for (int k = 0; k < 6; k++) read_chk(BASE + 32'(4 * k));
         read_chk(BASE - 32'h10 + 32'($urandom_range(0, 63)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
